// File: rtl/aes_ctr_pkg.sv
// Shared constants and types for the AES-CTR keystream consumer.
// Block geometry, per-mode message lengths and FSM state encoding.
package aes_ctr_pkg;

  localparam int BLOCK_SIZE        = 128;
  localparam int BATCH_BLOCKS      = 16;
  localparam int BATCH_W           = BLOCK_SIZE * BATCH_BLOCKS;
  localparam int XOF_TARGET_BLOCKS = 44;
  localparam int PRF_TARGET_BLOCKS = 8;
  localparam int PTR_W             = 4;
  localparam int CNT_W             = 6;

  localparam logic MODE_XOF = 1'b0;
  localparam logic MODE_PRF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Message length in blocks for the selected mode
  function automatic logic [CNT_W-1:0] target_for(input logic m);
    return (m == MODE_PRF) ? CNT_W'(PRF_TARGET_BLOCKS)
                           : CNT_W'(XOF_TARGET_BLOCKS);
  endfunction

endpackage

// File: rtl/aes_ctr_keystream_xor_ks_pingpong_buf.sv
// Two-slot ping-pong keystream batch buffer.
// Slots fill in order on wr_q and drain in order on rd_q.
module ks_pingpong_buf
  import aes_ctr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  cap_i,
  input  logic [BATCH_W-1:0]    batch_i,
  input  logic                  free_i,
  input  logic [PTR_W-1:0]      blk_ptr_i,
  output logic                  rd_full_o,
  output logic [BLOCK_SIZE-1:0] ks_blk_o,
  output logic                  ovf_o
);

  logic [BATCH_W-1:0] slot_q [2];
  logic [1:0]         full_q;
  logic               rd_q;
  logic               wr_q;
  logic               wr_free;
  logic               cap_ok;
  logic [10:0]        bit_base;

  // A slot being drained this cycle counts as free for capture
  assign wr_free   = !full_q[wr_q] || (free_i && (rd_q == wr_q));
  assign cap_ok    = cap_i && wr_free;
  assign ovf_o     = cap_i && !wr_free;
  assign rd_full_o = full_q[rd_q];
  assign bit_base  = {blk_ptr_i, 7'b0};
  assign ks_blk_o  = slot_q[rd_q][bit_base +: BLOCK_SIZE];

  // Slot occupancy and read/write slot pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 2'b00;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else if (clear_i) begin
      full_q <= 2'b00;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      if (free_i) begin
        full_q[rd_q] <= 1'b0;
        rd_q         <= ~rd_q;
      end
      if (cap_ok) begin
        full_q[wr_q] <= 1'b1;
        wr_q         <= ~wr_q;
      end
    end
  end

  // Batch storage; contents only matter once the full flag is set
  always_ff @(posedge clk_i) begin
    if (cap_ok) begin
      slot_q[wr_q] <= batch_i;
    end
  end

endmodule

// File: rtl/aes_ctr_keystream_xor.sv
// AES-256 CTR keystream consumer: batch capture plus stream XOR.
// Ends each message after the mode's block count, then pulses done.
module aes_ctr_keystream_xor
  import aes_ctr_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mode,
  input  logic                               start,
  input  logic [BLOCK_SIZE*BATCH_BLOCKS-1:0] batch_in,
  input  logic                               batch_valid,
  input  logic [BLOCK_SIZE-1:0]              data_in,
  input  logic                               data_in_valid,
  output logic                               data_in_ready,
  output logic [BLOCK_SIZE-1:0]              data_out,
  output logic                               data_out_valid,
  input  logic                               data_out_ready,
  output logic                               data_out_last,
  output logic                               done,
  output logic                               busy,
  output logic                               overflow
);

  state_e                state_q;
  logic [CNT_W-1:0]      target_q;
  logic [PTR_W-1:0]      blk_ptr_q;
  logic [CNT_W-1:0]      blk_cnt_q;
  logic [BLOCK_SIZE-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  dout_last_q;
  logic                  done_q;
  logic                  overflow_q;

  logic                  run;
  logic                  rd_full;
  logic                  ks_avail;
  logic [BLOCK_SIZE-1:0] ks_blk;
  logic                  in_hs;
  logic                  out_hs;
  logic                  is_last;
  logic                  ptr_wrap;
  logic                  free;
  logic                  cap;
  logic                  clear;
  logic                  ovf_set;

  assign run      = (state_q == ST_RUN);
  assign ks_avail = rd_full && run;
  assign data_in_ready =
    ks_avail && (!dout_valid_q || data_out_ready);
  assign in_hs    = data_in_valid && data_in_ready;
  assign out_hs   = dout_valid_q && data_out_ready;
  assign is_last  = (blk_cnt_q == (target_q - CNT_W'(1)));
  assign ptr_wrap = (blk_ptr_q == PTR_W'(BATCH_BLOCKS - 1));
  assign free     = in_hs && (is_last || ptr_wrap);
  assign cap      = batch_valid && (state_q != ST_IDLE);
  assign clear    = (state_q == ST_IDLE) && start;

  assign data_out       = dout_q;
  assign data_out_valid = dout_valid_q;
  assign data_out_last  = dout_last_q;
  assign done           = done_q;
  assign busy           = (state_q != ST_IDLE);
  assign overflow       = overflow_q;

  ks_pingpong_buf u_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (clear),
    .cap_i     (cap),
    .batch_i   (batch_in),
    .free_i    (free),
    .blk_ptr_i (blk_ptr_q),
    .rd_full_o (rd_full),
    .ks_blk_o  (ks_blk),
    .ovf_o     (ovf_set)
  );

  // Message FSM, block counters and registered XOR output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      blk_ptr_q    <= '0;
      blk_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            target_q   <= target_for(mode);
            blk_ptr_q  <= '0;
            blk_cnt_q  <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (in_hs) begin
            dout_q       <= data_in ^ ks_blk;
            dout_valid_q <= 1'b1;
            dout_last_q  <= is_last;
            blk_cnt_q    <= blk_cnt_q + CNT_W'(1);
            blk_ptr_q    <= free ? '0 : blk_ptr_q + PTR_W'(1);
            if (is_last) begin
              state_q <= ST_FLUSH;
            end
          end else if (out_hs) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (out_hs) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_keystream_xor.sv
// Directed bench for the AES-CTR keystream consumer.
// Expected blocks come from a bench-side batch pattern and queue.
module tb_aes_ctr_keystream_xor;
  import aes_ctr_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          start;
  logic [2047:0] batch_in;
  logic          batch_valid;
  logic [127:0]  data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [127:0]  data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_last;
  logic          done;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_ctr_keystream_xor dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .start          (start),
    .batch_in       (batch_in),
    .batch_valid    (batch_valid),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last),
    .done           (done),
    .busy           (busy),
    .overflow       (overflow)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Block i of a batch is the byte (seed+i) replicated 16 times
  function automatic logic [2047:0] mk(input logic [7:0] seed);
    logic [2047:0] r;
    logic [7:0]    v;
    for (int i = 0; i < 16; i++) begin
      v = seed + 8'(i);
      r[i*128 +: 128] = {16{v}};
    end
    return r;
  endfunction

  function automatic logic [127:0] blk(input logic [2047:0] b,
                                       input int i);
    return b[i*128 +: 128];
  endfunction

  task automatic push_blks(input logic [2047:0] b,
                           input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(blk(b, i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_batch(input logic [2047:0] b);
    batch_in    = b;
    batch_valid = 1'b1;
    cyc();
    batch_valid = 1'b0;
  endtask

  task automatic do_start(input logic m);
    mode  = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_dout"},  data_out, '0);
    chk({t, "_dvld"},  data_out_valid, '0);
    chk({t, "_last"},  data_out_last, '0);
    chk({t, "_done"},  done, '0);
    chk({t, "_busy"},  busy, '0);
    chk({t, "_ovf"},   overflow, '0);
    chk({t, "_ready"}, data_in_ready, '0);
  endtask

  // Feed din continuously; check outputs against exp_q in order
  task automatic stream(input string t, input logic [127:0] din,
                        input int n, input int stop,
                        input int budget);
    int k;
    bit seen_last;
    k = 0;
    seen_last = 0;
    data_in        = din;
    data_in_valid  = 1'b1;
    data_out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (seen_last) begin
        chk({t, "_done"}, done, 1);
        chk({t, "_busy_end"}, busy, 0);
        data_in_valid = 1'b0;
        return;
      end
      if (data_out_valid) begin
        chk($sformatf("%s_data[%0d]", t, k),
            data_out, din ^ exp_q[k]);
        chk($sformatf("%s_last[%0d]", t, k),
            data_out_last, 128'(k == n - 1));
        if (k == n - 1) seen_last = 1;
        k++;
        if (k == stop && !seen_last) return;
      end
      cyc();
    end
    chk({t, "_timeout"}, k, stop);
    data_in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2047:0] b0, b1, b2;
    logic [127:0]  din;
    int hs;

    rst = 1'b1;
    mode = 1'b0;
    start = 1'b0;
    batch_in = '0;
    batch_valid = 1'b0;
    data_in = '0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    cyc();
    cyc();
    chk_zero("reset");
    rst = 1'b0;
    cyc();

    // PRF basic: keystream passes through with zero data
    do_start(MODE_PRF);
    b0 = mk(8'h00);
    pulse_batch(b0);
    exp_q.delete();
    push_blks(b0, 0, 7);
    stream("prf", '0, 8, 8, 100);
    chk("prf_ovf", overflow, 0);

    // XOF across three batches, 16+16+12 blocks
    do_start(MODE_XOF);
    b0 = mk(8'h10);
    b1 = mk(8'h30);
    b2 = mk(8'h50);
    exp_q.delete();
    push_blks(b0, 0, 15);
    push_blks(b1, 0, 15);
    push_blks(b2, 0, 11);
    fork
      begin
        pulse_batch(b0);
        repeat (14) cyc();
        pulse_batch(b1);
        repeat (14) cyc();
        pulse_batch(b2);
      end
      begin
        stream("xof", '1, 44, 44, 300);
      end
    join
    chk("xof_ovf", overflow, 0);

    // Backpressure: output held while extra batches overflow
    do_start(MODE_PRF);
    b0 = mk(8'h70);
    din = {4{32'h5555_aaaa}};
    pulse_batch(b0);
    data_in = din;
    data_in_valid = 1'b1;
    data_out_ready = 1'b0;
    cyc();
    chk("bp_vld0", data_out_valid, 1);
    chk("bp_hold0", data_out, din ^ blk(b0, 0));
    pulse_batch(mk(8'h90));
    chk("bp_hold1", data_out, din ^ blk(b0, 0));
    chk("bp_ovf_2nd", overflow, 0);
    pulse_batch(mk(8'hb0));
    chk("bp_hold2", data_out, din ^ blk(b0, 0));
    chk("bp_ovf_3rd", overflow, 1);
    pulse_batch(mk(8'hd0));
    chk("bp_hold3", data_out, din ^ blk(b0, 0));
    chk("bp_vld3", data_out_valid, 1);
    exp_q.delete();
    push_blks(b0, 0, 7);
    stream("bp", din, 8, 8, 100);
    chk("bp_ovf_sticky", overflow, 1);

    // Capture lands on the cycle the full read slot drains
    do_start(MODE_XOF);
    chk("sim_ovf_clr", overflow, 0);
    b0 = mk(8'ha0);
    b1 = mk(8'hb0);
    b2 = mk(8'hc0);
    pulse_batch(b0);
    pulse_batch(b1);
    data_in = '0;
    data_in_valid = 1'b1;
    data_out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 100 && hs < 16; c++) begin
      if (data_in_ready) begin
        if (hs == 15) begin
          batch_in = b2;
          batch_valid = 1'b1;
        end
        hs++;
      end
      cyc();
      batch_valid = 1'b0;
    end
    chk("sim_hs", hs, 16);
    chk("sim_ovf", overflow, 0);
    exp_q.delete();
    push_blks(b0, 15, 15);
    push_blks(b1, 0, 15);
    push_blks(b2, 0, 11);
    stream("sim", '0, 29, 29, 200);
    chk("sim_ovf_end", overflow, 0);

    // IDLE batch ignored; start during RUN ignored
    pulse_batch(mk(8'he0));
    chk("idle_busy", busy, 0);
    do_start(MODE_PRF);
    b0 = mk(8'h20);
    pulse_batch(b0);
    do_start(MODE_XOF);
    chk("ign_busy", busy, 1);
    din = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    exp_q.delete();
    push_blks(b0, 0, 7);
    stream("ign", din, 8, 8, 100);

    // Reset mid-message, then a fresh message
    do_start(MODE_PRF);
    b0 = mk(8'h60);
    pulse_batch(b0);
    exp_q.delete();
    push_blks(b0, 0, 7);
    stream("pre", '0, 8, 5, 100);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    cyc();
    chk_zero("mid_rst2");
    data_in_valid = 1'b0;
    rst = 1'b0;
    cyc();
    chk("post_rst_busy", busy, 0);
    do_start(MODE_PRF);
    b0 = mk(8'hd0);
    pulse_batch(b0);
    exp_q.delete();
    push_blks(b0, 0, 7);
    stream("post", '0, 8, 8, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_ctr_keystream_xor.md
Name: aes_ctr_keystream_xor

Overview:
- Consumer end of the AES-256 CTR keystream generator.
- Captures each 16-block keystream batch on the generator's one-cycle `finished` pulse and holds it in a two-slot ping-pong buffer.
- XORs keystream blocks, in order, with a valid/ready 128-bit data stream (encrypt = decrypt).
- Terminates after the mode's target block count (XOF 44, PRF 8).

Parameters:
- BLOCK_SIZE, 128, bits per keystream/data block.
- BATCH_BLOCKS, 16, blocks per captured batch.
- XOF_TARGET_BLOCKS, 44, blocks per message when mode=0.
- PRF_TARGET_BLOCKS, 8, blocks per message when mode=1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0=XOF, 1=PRF; sampled on start.
- start  in  1  begin a message (one-cycle pulse).
- batch_in  in  BLOCK_SIZE*BATCH_BLOCKS  keystream batch; block i at bits [(i+1)*128-1 -: 128], block 0 consumed first.
- batch_valid  in  1  generator finished pulse; batch_in valid this cycle.
- data_in  in  BLOCK_SIZE  plaintext/ciphertext block.
- data_in_valid  in  1  data_in valid.
- data_in_ready  out  1  block accepted when valid&&ready.
- data_out  out  BLOCK_SIZE  data_in XOR keystream.
- data_out_valid  out  1  data_out valid.
- data_out_ready  in  1  downstream accepts.
- data_out_last  out  1  marks final block of message.
- done  out  1  one-cycle pulse after last block handshake.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky; batch dropped because both slots full.

Behaviour:
- Reset: all outputs 0; state IDLE; both slots empty; rd_slot=0, wr_slot=0, blk_ptr=0, blk_cnt=0; buffers need not be cleared.
- States:
  - IDLE: batch_valid ignored. start → RUN; latches target = mode ? PRF_TARGET_BLOCKS : XOF_TARGET_BLOCKS; clears slots, pointers, blk_cnt, overflow.
  - RUN: normal operation.
  - FLUSH: last block issued; waits for the data_out_last handshake, then pulses done and returns to IDLE.
- start outside IDLE is ignored.
- Capture (RUN/FLUSH):
  - batch_valid with a free slot writes batch_in to slot wr_slot, marks it full, toggles wr_slot.
  - A slot freed in the same cycle counts as free, so capture succeeds.
  - With no free slot, the batch is dropped and overflow is set to 1.
  - In FLUSH, batches are captured but never used; they are cleared on the next start.
- Keystream available when slot[rd_slot] is full and state==RUN.
- data_in_ready = RUN && ks_avail && (!data_out_valid || data_out_ready).
- Input handshake:
  - data_out <= data_in ^ slot[rd_slot].block[blk_ptr]; data_out_valid <= 1.
  - blk_cnt increments.
  - Latency: one cycle from input handshake to data_out_valid.
- Output hold: data_out / data_out_valid / data_out_last are held stable while data_out_valid && !data_out_ready. Valid drops after a handshake with no new input.
- Pointer advance:
  - blk_ptr increments (4-bit).
  - At blk_ptr==BATCH_BLOCKS-1: current slot freed, rd_slot toggled, blk_ptr=0.
- Last block (blk_cnt==target-1 at handshake):
  - data_out_last <= 1; state → FLUSH.
  - Current slot freed regardless of blk_ptr (remaining blocks discarded); blk_ptr=0.
  - Examples: XOF uses blocks 0..11 of the 3rd batch; PRF uses blocks 0..7 of the 1st batch.
- blk_cnt is 6 bits; targets must be ≤63 and ≥1.
- done asserts the cycle after the final output handshake; busy drops the same cycle.
- Reset mid-message: immediate return to reset values; the partial message is abandoned.

Decomposition:
- Shared package aes_ctr_pkg:
  - BLOCK_SIZE, BATCH_BLOCKS, XOF/PRF target constants.
  - MODE_XOF=0, MODE_PRF=1.
  - State encoding IDLE/RUN/FLUSH.
- One sub-module, ks_pingpong_buf: two 2048-bit slots, full flags, wr/rd slot pointers, block select mux.
- FSM, counters and XOR datapath stay in the top.

Test Plan:
- PRF basic:
  - Stimulus: mode=1, start, batch with block i = {16{i[7:0]}}, data_in=0, ready=1.
  - Response: 8 outputs equal blocks 0..7; last on the 8th; done next cycle; overflow=0.
- XOF across batches:
  - Stimulus: mode=0, three batches pulsed 15 cycles apart, data_in=all-ones.
  - Response: 44 outputs = ~keystream in order (16+16+12); last only on the 44th; 3rd batch blocks 12..15 discarded.
- Backpressure overflow:
  - Stimulus: data_out_ready=0 after the first output, four batch_valid pulses.
  - Response: data_out stable throughout; overflow=1 after the 3rd pulse; no keystream corruption once ready=1.
- Simultaneous free/capture:
  - Stimulus: batch_valid on the same cycle the 16th block of a full slot is consumed, other slot full.
  - Response: capture succeeds; overflow stays 0.
- IDLE filtering / start ignore:
  - Stimulus: batch_valid in IDLE; start during RUN.
  - Response: no capture (first post-start output uses the post-start batch); message count unaffected.
- Reset mid-message:
  - Stimulus: assert rst after 5 PRF blocks, then restart.
  - Response: all outputs 0 during reset; new message yields 8 blocks from the fresh batch.
